// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared state type and address-width helper for the multi-port register file
package regfile_mp_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    function automatic int rf_addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus into the register file
interface regfile_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [DATA_W-1:0]          pc;
    logic                       busy_set_en;
    logic [ADDR_W-1:0]          busy_set_addr;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_busy;
    logic                       init_done;

    modport master (
        output wr_en, wr_addr, wr_data, pc, busy_set_en, busy_set_addr, rd_addr,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, pc, busy_set_en, busy_set_addr, rd_addr,
        output rd_data, rd_busy, init_done
    );

endinterface

// File: rtl/regfile_mp_read_port.sv
// regfile_mp_read_port: one combinational read port with PC mapping, range check, bypass and busy gating
module regfile_mp_read_port #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int PC_REG   = 15,
    parameter int PC_SHIFT = 2,
    parameter int BYPASS   = 1
) (
    input  logic              ready_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              busy_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);
    logic              is_pc;
    logic              in_range;
    logic              hit;
    logic [DATA_W-1:0] pc_word;

    assign is_pc    = int'(addr_i) == PC_REG;
    assign in_range = int'(addr_i) < NUM_REGS;
    assign hit      = BYPASS != 0 && wr_en_i && wr_addr_i == addr_i;
    assign pc_word  = pc_i >> PC_SHIFT;

    // PC mapping outranks the range check, which outranks the bypass; a retiring write is never busy
    always_comb begin
        rd_data_o = (!ready_i || (!is_pc && !in_range)) ? '0 :
                    is_pc ? pc_word : hit ? wr_data_i : mem_data_i;
        rd_busy_o = ready_i && !is_pc && in_range && !hit && busy_i;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with PC mapping, scoreboard and post-reset clear
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int PC_REG   = 15,
    parameter int PC_SHIFT = 2,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int ADDR_W = rf_addr_w(NUM_REGS);

    rf_state_e                      state_q;
    logic [ADDR_W-1:0]              clr_cnt_q;
    logic [NUM_REGS-1:0]            busy_q;
    logic [NUM_REGS-1:0]            busy_d;
    logic                           init_done_q;
    logic [DATA_W-1:0]              mem_q [NUM_REGS];
    logic                           ready;
    logic                           wr_ok;
    logic                           set_ok;
    logic                           mem_we;
    logic [ADDR_W-1:0]              mem_wa;
    logic [DATA_W-1:0]              mem_wd;
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]              rd_busy;

    assign ready  = state_q == RF_READY;
    assign wr_ok  = ready && bus.wr_en && int'(bus.wr_addr) < NUM_REGS && int'(bus.wr_addr) != PC_REG;
    assign set_ok = ready && bus.busy_set_en && int'(bus.busy_set_addr) < NUM_REGS &&
                    int'(bus.busy_set_addr) != PC_REG;
    assign mem_we = !reset && (!ready || wr_ok);
    assign mem_wa = ready ? bus.wr_addr : clr_cnt_q;
    assign mem_wd = ready ? bus.wr_data : '0;

    // Retiring write clears its pending bit; a new issue to the same register wins
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) busy_d[bus.wr_addr] = 1'b0;
        if (set_ok) busy_d[bus.busy_set_addr] = 1'b1;
    end

    // Clear sequence walks every entry once, then the file accepts writes and issues
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RF_CLEAR;
            clr_cnt_q   <= '0;
            busy_q      <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == RF_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (int'(clr_cnt_q) == NUM_REGS - 1) begin
                state_q     <= RF_READY;
                init_done_q <= 1'b1;
            end
        end else begin
            busy_q <= busy_d;
        end
    end

    // Storage is zeroed by the clear walk rather than by reset, so it needs no reset branch
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
        regfile_mp_read_port #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
            .PC_REG(PC_REG), .PC_SHIFT(PC_SHIFT), .BYPASS(BYPASS)
        ) u_port (
            .ready_i    (ready),
            .addr_i     (addr),
            .mem_data_i (mem_q[addr]),
            .busy_i     (busy_q[addr]),
            .wr_en_i    (bus.wr_en),
            .wr_addr_i  (bus.wr_addr),
            .wr_data_i  (bus.wr_data),
            .pc_i       (bus.pc),
            .rd_data_o  (rd_data[i]),
            .rd_busy_o  (rd_busy[i])
        );
    end

    assign bus.rd_data   = rd_data;
    assign bus.rd_busy   = rd_busy;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of two register file configurations against an array model
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, bs_en;
    logic [3:0]  wr_addr, bs_addr, ra0, ra1;
    logic [15:0] wr_data, pc;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) ifa();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) ifb();

    assign ifa.wr_en = wr_en;     assign ifb.wr_en = wr_en;
    assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
    assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
    assign ifa.pc = pc;           assign ifb.pc = pc;
    assign ifa.busy_set_en = bs_en;     assign ifb.busy_set_en = bs_en;
    assign ifa.busy_set_addr = bs_addr; assign ifb.busy_set_addr = bs_addr;
    assign ifa.rd_addr = {ra1, ra0};    assign ifb.rd_addr = {ra1, ra0};

    regfile_mp dut_a (.clk(clk), .reset(reset), .bus(ifa));
    regfile_mp #(.NUM_REGS(12), .BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    // Reference model: index 0 = default config, index 1 = 12 registers without bypass
    int          nregs [2] = '{16, 12};
    int          byp   [2] = '{1, 0};
    logic [15:0] m_mem [2][16];
    bit          m_busy[2][16];
    int          m_cnt [2] = '{0, 0};
    int          n_err = 0;
    int          n_chk = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(int k);
        return m_cnt[k] >= nregs[k];
    endfunction

    function automatic logic [16:0] exp_rd(int k, logic [3:0] a);
        if (!m_ready(k)) return '0;
        if (a == 4'd15) return {1'b0, pc >> 2};
        if (int'(a) >= nregs[k]) return '0;
        if (byp[k] != 0 && wr_en && wr_addr == a) return {1'b0, wr_data};
        return {m_busy[k][a], m_mem[k][a]};
    endfunction

    function automatic logic [15:0] rdd(int k, int p);
        logic [31:0] d = (k == 0) ? ifa.rd_data : ifb.rd_data;
        return d[p*16 +: 16];
    endfunction

    function automatic logic rdb(int k, int p);
        logic [1:0] b = (k == 0) ? ifa.rd_busy : ifb.rd_busy;
        return b[p];
    endfunction

    task automatic model_clock(int k);
        if (reset) begin
            m_cnt[k] = 0;
            for (int i = 0; i < 16; i++) m_busy[k][i] = 1'b0;
        end else if (!m_ready(k)) begin
            m_cnt[k]++;
            if (m_ready(k)) for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
        end else begin
            if (wr_en && wr_addr != 4'd15 && int'(wr_addr) < nregs[k]) begin
                m_mem[k][wr_addr]  = wr_data;
                m_busy[k][wr_addr] = 1'b0;
            end
            if (bs_en && bs_addr != 4'd15 && int'(bs_addr) < nregs[k]) m_busy[k][bs_addr] = 1'b1;
        end
    endtask

    task automatic settle();
        logic [16:0] e;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("init%0d", k), {15'b0, (k == 0) ? ifa.init_done : ifb.init_done},
                {15'b0, m_ready(k)});
            for (int p = 0; p < 2; p++) begin
                e = exp_rd(k, (p == 0) ? ra0 : ra1);
                chk($sformatf("data%0d_%0d", k, p), rdd(k, p), e[15:0]);
                chk($sformatf("busy%0d_%0d", k, p), {15'b0, rdb(k, p)}, {15'b0, e[16]});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock(0);
        model_clock(1);
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; bs_en = 0; bs_addr = 0; ra0 = 0; ra1 = 0; pc = 0;
    endtask

    task automatic clear_walk();
        for (int k = 0; k <= 16; k++) begin
            wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = 16'($urandom);
            bs_en = 1'b1; bs_addr = 4'($urandom); ra0 = 4'($urandom); ra1 = 4'($urandom);
            settle();
            chk("init16", {15'b0, ifa.init_done}, (k == 16) ? 16'd1 : 16'd0);
            if (k < 16) chk("clr_rd", rdd(0, 0), 16'h0);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        step();
        reset = 1'b0;
        clear_walk();

        wr_en = 1; wr_addr = 4'd3; wr_data = 16'hBEEF; ra0 = 4'd3; ra1 = 4'd3;
        settle();
        chk("byp_same", rdd(0, 0), 16'hBEEF);
        chk("nobyp_same", rdd(1, 1), m_mem[1][3]);
        tick();
        idle(); ra0 = 4'd3; ra1 = 4'd3;
        settle();
        chk("rd3_p0", rdd(0, 0), 16'hBEEF);
        chk("rd3_p1", rdd(0, 1), 16'hBEEF);
        chk("rd3_b", rdd(1, 0), 16'hBEEF);
        tick();

        pc = 16'h0124; ra0 = 4'd15;
        step();
        wr_en = 1; wr_addr = 4'd15; wr_data = 16'h1234;
        step();
        wr_en = 0;
        settle();
        chk("pc_rd", rdd(0, 0), 16'h0049);
        tick();

        idle(); bs_en = 1; bs_addr = 4'd5;
        step();
        bs_en = 0; ra1 = 4'd5;
        settle();
        chk("busy_set", {15'b0, rdb(0, 1)}, 16'd1);
        tick();
        wr_en = 1; wr_addr = 4'd5; wr_data = 16'h1111;
        settle();
        chk("busy_ret", {15'b0, rdb(0, 1)}, 16'd0);
        tick();
        bs_en = 1; bs_addr = 4'd5; wr_data = 16'h2222;
        step();
        idle(); ra1 = 4'd5;
        settle();
        chk("busy_setclr", {15'b0, rdb(0, 1)}, 16'd1);
        tick();

        wr_en = 1; wr_addr = 4'd7; wr_data = 16'hAAAA;
        step();
        idle(); reset = 1;
        step();
        reset = 0;
        repeat (4) step();
        reset = 1;
        step();
        reset = 0;
        clear_walk();
        ra0 = 4'd7;
        settle();
        chk("r7_cleared", rdd(0, 0), 16'h0);
        tick();

        bs_en = 1; bs_addr = 4'd13; ra0 = 4'd13;
        step();
        bs_en = 0;
        settle();
        chk("oor_data", rdd(1, 0), 16'h0);
        chk("oor_busy", {15'b0, rdb(1, 0)}, 16'd0);
        tick();

        for (int n = 0; n < 800; n++) begin
            reset   = ($urandom_range(0, 249) == 0);
            wr_en   = 1'($urandom);
            wr_addr = 4'($urandom);
            wr_data = 16'($urandom);
            bs_en   = 1'($urandom);
            bs_addr = 4'($urandom);
            ra0     = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
            ra1     = ($urandom_range(0, 3) == 0) ? bs_addr : 4'($urandom);
            pc      = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
